// File: rtl/drc_pxl_packer.sv
// Packs PXL_PER_WORD pixels per bus word with lane strobes, flushes on last, checks frame length.
// Latency 1 cycle from completing pixel to word valid; input stalls only while a finished word is parked.
module drc_pxl_packer #(
  parameter int I_PXL_W      = 8,
  parameter int PXL_PER_WORD = 4,
  parameter int FRM_PXL_NUM  = 76800,
  parameter int FRM_CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [I_PXL_W-1:0]                bwd_pxl_data_i,
  input  logic                              bwd_pxl_last_i,
  input  logic                              bwd_pxl_vld_i,
  output logic                              bwd_pxl_rdy_o,
  output logic [I_PXL_W*PXL_PER_WORD-1:0]   fwd_word_data_o,
  output logic [PXL_PER_WORD-1:0]           fwd_word_strb_o,
  output logic                              fwd_word_last_o,
  output logic                              fwd_word_vld_o,
  input  logic                              fwd_word_rdy_i,
  output logic                              frm_err_o,
  output logic [FRM_CNT_W-1:0]              frm_cnt_o
);

  localparam int WORD_W = I_PXL_W * PXL_PER_WORD;
  localparam int IDX_W  = $clog2(PXL_PER_WORD);
  localparam int PCNT_W = (FRM_PXL_NUM > 1) ? $clog2(FRM_PXL_NUM) : 1;
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(PXL_PER_WORD - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(FRM_PXL_NUM - 1);

  logic [WORD_W-1:0]       acc_data_q, acc_data_d;
  logic [IDX_W-1:0]        acc_idx_q, acc_idx_d;
  logic                    acc_done_q, acc_done_d;
  logic                    acc_last_q, acc_last_d;
  logic                    rdy_q, rdy_d;
  logic [WORD_W-1:0]       out_data_q, out_data_d;
  logic [PXL_PER_WORD-1:0] out_strb_q, out_strb_d;
  logic                    out_last_q, out_last_d;
  logic                    out_vld_q, out_vld_d;
  logic [PCNT_W-1:0]       pxl_cnt_q, pxl_cnt_d;
  logic                    frm_err_q, frm_err_d;
  logic [FRM_CNT_W-1:0]    frm_cnt_q, frm_cnt_d;

  logic                    bwd_hsk, fwd_hsk, out_free, completing, at_end;
  logic [WORD_W-1:0]       cur_word;
  logic [PXL_PER_WORD-1:0] cur_strb;

  assign bwd_hsk    = bwd_pxl_vld_i & rdy_q;
  assign fwd_hsk    = out_vld_q & fwd_word_rdy_i;
  assign out_free   = ~out_vld_q | fwd_hsk;
  assign completing = (acc_idx_q == IDX_MAX) | bwd_pxl_last_i;
  assign at_end     = (pxl_cnt_q == PCNT_MAX);

  // Lanes above acc_idx are already zero because the accumulator clears whenever a word leaves it.
  always_comb begin
    cur_word = acc_data_q;
    cur_strb = '0;
    for (int l = 0; l < PXL_PER_WORD; l++) begin
      if (IDX_W'(l) == acc_idx_q) cur_word[l*I_PXL_W +: I_PXL_W] = bwd_pxl_data_i;
      cur_strb[l] = (IDX_W'(l) <= acc_idx_q);
    end
  end

  always_comb begin
    acc_data_d = acc_data_q;
    acc_idx_d  = acc_idx_q;
    acc_done_d = acc_done_q;
    acc_last_d = acc_last_q;
    out_data_d = out_data_q;
    out_strb_d = out_strb_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q & ~fwd_hsk;
    pxl_cnt_d  = pxl_cnt_q;
    frm_err_d  = 1'b0;
    frm_cnt_d  = frm_cnt_q;

    if (acc_done_q) begin
      if (out_free) begin
        out_data_d = acc_data_q;
        out_strb_d = cur_strb;
        out_last_d = acc_last_q;
        out_vld_d  = 1'b1;
        acc_data_d = '0;
        acc_idx_d  = '0;
        acc_last_d = 1'b0;
        acc_done_d = 1'b0;
      end
    end else if (bwd_hsk) begin
      if (!completing) begin
        acc_data_d = cur_word;
        acc_idx_d  = acc_idx_q + 1'b1;
      end else if (out_free) begin
        out_data_d = cur_word;
        out_strb_d = cur_strb;
        out_last_d = bwd_pxl_last_i;
        out_vld_d  = 1'b1;
        acc_data_d = '0;
        acc_idx_d  = '0;
      end else begin
        // Output still busy: park the finished word, acc_idx keeps its strobe extent.
        acc_data_d = cur_word;
        acc_last_d = bwd_pxl_last_i;
        acc_done_d = 1'b1;
      end
    end

    if (bwd_hsk) begin
      frm_err_d = bwd_pxl_last_i ^ at_end;
      pxl_cnt_d = (bwd_pxl_last_i | at_end) ? '0 : pxl_cnt_q + 1'b1;
      if (bwd_pxl_last_i) frm_cnt_d = frm_cnt_q + 1'b1;
    end

    rdy_d = ~acc_done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data_q <= '0;
      acc_idx_q  <= '0;
      acc_done_q <= 1'b0;
      acc_last_q <= 1'b0;
      rdy_q      <= 1'b0;
      out_data_q <= '0;
      out_strb_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      pxl_cnt_q  <= '0;
      frm_err_q  <= 1'b0;
      frm_cnt_q  <= '0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_idx_q  <= acc_idx_d;
      acc_done_q <= acc_done_d;
      acc_last_q <= acc_last_d;
      rdy_q      <= rdy_d;
      out_data_q <= out_data_d;
      out_strb_q <= out_strb_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
      pxl_cnt_q  <= pxl_cnt_d;
      frm_err_q  <= frm_err_d;
      frm_cnt_q  <= frm_cnt_d;
    end
  end

  assign bwd_pxl_rdy_o   = rdy_q;
  assign fwd_word_data_o = out_data_q;
  assign fwd_word_strb_o = out_strb_q;
  assign fwd_word_last_o = out_last_q;
  assign fwd_word_vld_o  = out_vld_q;
  assign frm_err_o       = frm_err_q;
  assign frm_cnt_o       = frm_cnt_q;

endmodule

// File: tb/tb_drc_pxl_packer.sv
// Bench for drc_pxl_packer: directed and random streams against a queue-based packing/frame model.
module tb_drc_pxl_packer;

  localparam int FRM = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bwd_pxl_data_i = '0;
  logic        bwd_pxl_last_i = 1'b0;
  logic        bwd_pxl_vld_i = 1'b0;
  logic        bwd_pxl_rdy_o;
  logic [31:0] fwd_word_data_o;
  logic [3:0]  fwd_word_strb_o;
  logic        fwd_word_last_o;
  logic        fwd_word_vld_o;
  logic        fwd_word_rdy_i;
  logic        frm_err_o;
  logic [15:0] frm_cnt_o;

  drc_pxl_packer #(.I_PXL_W(8), .PXL_PER_WORD(4), .FRM_PXL_NUM(FRM), .FRM_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .bwd_pxl_data_i(bwd_pxl_data_i), .bwd_pxl_last_i(bwd_pxl_last_i),
    .bwd_pxl_vld_i(bwd_pxl_vld_i), .bwd_pxl_rdy_o(bwd_pxl_rdy_o),
    .fwd_word_data_o(fwd_word_data_o), .fwd_word_strb_o(fwd_word_strb_o),
    .fwd_word_last_o(fwd_word_last_o), .fwd_word_vld_o(fwd_word_vld_o),
    .fwd_word_rdy_i(fwd_word_rdy_i), .frm_err_o(frm_err_o), .frm_cnt_o(frm_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0: sink stalls, 1: sink always ready, 2: sink ready at random
  int rdy_mode = 0;
  initial begin
    fwd_word_rdy_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       fwd_word_rdy_i = 1'b0;
        1:       fwd_word_rdy_i = 1'b1;
        default: fwd_word_rdy_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: pixels collect into a word until four are held or last arrives;
  // a frame is FRM pixels ending with last.
  bit          mon_en = 0;
  logic [7:0]  cur_pix[$];
  logic [36:0] exp_q[$];
  int          frm_pos = 0;
  logic        err_exp = 1'b0;
  logic [15:0] cnt_exp = '0;
  bit          hold = 0;
  logic [36:0] hold_word = '0;

  task automatic model_clear();
    cur_pix.delete();
    exp_q.delete();
    frm_pos   = 0;
    err_exp   = 1'b0;
    cnt_exp   = '0;
    hold      = 0;
    hold_word = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [36:0] obs_word;
      obs_word = {fwd_word_last_o, fwd_word_strb_o, fwd_word_data_o};
      chk("frm_err", frm_err_o, err_exp);
      chk("frm_cnt", frm_cnt_o, cnt_exp);
      if (hold) begin
        chk("hold_vld", fwd_word_vld_o, 1);
        chk("hold_word", obs_word, hold_word);
      end
      if (fwd_word_vld_o && fwd_word_rdy_i) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("word", obs_word, exp_q.pop_front());
      end
      hold      = fwd_word_vld_o && !fwd_word_rdy_i;
      hold_word = obs_word;
      err_exp   = 1'b0;
      if (bwd_pxl_vld_i && bwd_pxl_rdy_o) begin
        cur_pix.push_back(bwd_pxl_data_i);
        if (bwd_pxl_last_i || cur_pix.size() == 4) begin
          logic [31:0] w;
          logic [3:0]  s;
          w = '0;
          foreach (cur_pix[k]) w[k*8 +: 8] = cur_pix[k];
          s = 4'((1 << cur_pix.size()) - 1);
          exp_q.push_back({bwd_pxl_last_i, s, w});
          cur_pix.delete();
        end
        frm_pos++;
        if (bwd_pxl_last_i) begin
          err_exp = (frm_pos != FRM);
          frm_pos = 0;
          cnt_exp = cnt_exp + 16'd1;
        end else if (frm_pos == FRM) begin
          err_exp = 1'b1;
          frm_pos = 0;
        end
      end
    end
  end

  // All steps start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic l);
    bit h = 0;
    bwd_pxl_data_i = d;
    bwd_pxl_last_i = l;
    bwd_pxl_vld_i  = 1'b1;
    for (int c = 0; c < 50 && !h; c++) begin
      @(negedge clk);
      h = bwd_pxl_rdy_o;
      @(posedge clk);
      #1;
    end
    bwd_pxl_vld_i  = 1'b0;
    bwd_pxl_last_i = 1'b0;
    chk("send_hsk", h, 1);
  endtask

  task automatic do_reset();
    mon_en = 0;
    bwd_pxl_vld_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_rdy", bwd_pxl_rdy_o, 0);
    chk("rst_vld", fwd_word_vld_o, 0);
    chk("rst_data", fwd_word_data_o, 0);
    chk("rst_strb", fwd_word_strb_o, 0);
    chk("rst_last", fwd_word_last_o, 0);
    chk("rst_err", frm_err_o, 0);
    chk("rst_cnt", frm_cnt_o, 0);
    model_clear();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", bwd_pxl_rdy_o, 1);
    mon_en = 1;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && (exp_q.size() != 0 || fwd_word_vld_o); c++) begin
      @(posedge clk);
      #1;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Test 1: two full words, valid right after 4th and 8th pixel
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 1'b0);
      chk("t1_vld_timing", fwd_word_vld_o, (i % 4) == 3);
    end
    chk("t1_word2", fwd_word_data_o, 32'h08070605);
    chk("t1_strb2", fwd_word_strb_o, 4'hF);
    wait_drain();

    // Test 2: proper 6-pixel frame, partial final word
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), i == 5);
    chk("t2_word", fwd_word_data_o, 32'h0000A5A4);
    chk("t2_strb", fwd_word_strb_o, 4'h3);
    chk("t2_last", fwd_word_last_o, 1);
    chk("t2_err", frm_err_o, 0);
    chk("t2_cnt", frm_cnt_o, 1);
    wait_drain();

    // Test 3: sink stalled, second word parks and input stalls
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(8'(8'h31 + i), 1'b0);
    chk("t3_rdy_low", bwd_pxl_rdy_o, 0);
    chk("t3_held_data", fwd_word_data_o, 32'h34333231);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("t3_rdy_still_low", bwd_pxl_rdy_o, 0);
    chk("t3_held_vld", fwd_word_vld_o, 1);
    rdy_mode = 1;
    wait_drain();
    chk("t3_rdy_back", bwd_pxl_rdy_o, 1);

    // Test 4: early last on 3rd pixel, then a clean frame
    do_reset();
    rdy_mode = 1;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b1);
    chk("t4_err", frm_err_o, 1);
    chk("t4_strb", fwd_word_strb_o, 4'h7);
    chk("t4_last", fwd_word_last_o, 1);
    for (int i = 0; i < 6; i++) send(8'(8'h50 + i), i == 5);
    chk("t4_clean_err", frm_err_o, 0);
    wait_drain();

    // Test 5: seven pixels without last, then last flushes
    for (int i = 0; i < 7; i++) begin
      send(8'(8'h70 + i), 1'b0);
      if (i == 5) chk("t5_err", frm_err_o, 1);
    end
    send(8'h77, 1'b1);
    chk("t5_word", fwd_word_data_o, 32'h77767574);
    chk("t5_strb", fwd_word_strb_o, 4'hF);
    wait_drain();

    // Test 6: reset with output held and two lanes filled
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(8'(8'h90 + i), 1'b0);
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
    chk("t6_word", fwd_word_data_o, 32'hC3C2C1C0);
    chk("t6_cnt", frm_cnt_o, 0);
    wait_drain();

    // Random frames of random length with a randomly stalling sink
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) send(8'($urandom), k == len - 1);
    end
    rdy_mode = 1;
    wait_drain();
    chk("rand_frm_cnt", frm_cnt_o, cnt_exp);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
